sample_delay_ctrl: RTL and testbench

- Circular-buffer controller that turns a dual-port synchronous RAM (one write port, one registered read port) into a programmable sample delay line.
- Drives the RAM's write and read ports and consumes its read data.
- Returns each input sample delayed by a runtime-selectable number of sample strobes.
- Sits between the signal-generator sample source and the output/DAC path; the RAM is instantiated beside it in the parent.

---
 rtl/sigdelay_pkg.sv | 13 +
 rtl/sample_delay_ctrl_if.sv | 35 +++
 rtl/sample_delay_ctrl.sv | 98 +++++++++
 tb/tb_sample_delay_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/sigdelay_pkg.sv
// Shared definitions for the sample delay line: default widths used by the parent
// that places the RAM beside the controller, and the controller state type.
package sigdelay_pkg;

   localparam int unsigned DEF_A_WIDTH = 9;
   localparam int unsigned DEF_D_WIDTH = 8;

   typedef enum logic {
      FILL,
      RUN
   } state_e;

endpackage

// File: rtl/sample_delay_ctrl_if.sv
// RAM-side port bundle of the delay controller: one write port and one registered
// read port. The controller is the master; the RAM is the slave.
interface sample_delay_ctrl_if
   import sigdelay_pkg::*;
#(
   parameter int unsigned A_WIDTH = DEF_A_WIDTH,
   parameter int unsigned D_WIDTH = DEF_D_WIDTH
);

   logic               ram_wr_en;
   logic [A_WIDTH-1:0] ram_wr_addr;
   logic [D_WIDTH-1:0] ram_din;
   logic               ram_rd_en;
   logic [A_WIDTH-1:0] ram_rd_addr;
   logic [D_WIDTH-1:0] ram_dout;

   modport master (
      output ram_wr_en,
      output ram_wr_addr,
      output ram_din,
      output ram_rd_en,
      output ram_rd_addr,
      input  ram_dout
   );

   modport slave (
      input  ram_wr_en,
      input  ram_wr_addr,
      input  ram_din,
      input  ram_rd_en,
      input  ram_rd_addr,
      output ram_dout
   );

endinterface

// File: rtl/sample_delay_ctrl.sv
// Circular-buffer controller that turns an external dual-port RAM into a delay line
// of runtime-selectable length; offset 0 selects the full buffer depth.
module sample_delay_ctrl
   import sigdelay_pkg::*;
#(
   parameter int unsigned A_WIDTH = DEF_A_WIDTH,
   parameter int unsigned D_WIDTH = DEF_D_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [A_WIDTH-1:0]  offset,
   input  logic [D_WIDTH-1:0]  din,
   output logic [D_WIDTH-1:0]  dout,
   output logic                dout_valid,
   sample_delay_ctrl_if.master ram
);

   state_e             state_q, state_d;
   logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [A_WIDTH-1:0] offset_q, offset_d;
   logic [A_WIDTH:0]   fill_q, fill_d;
   logic [A_WIDTH:0]   dly;
   logic               offset_chg;
   logic               rd_en;
   logic               s1_valid, s1_zero;

   always_comb begin
      dly = {1'b0, offset_q};
      if (offset_q == '0) begin
         dly = {1'b1, {A_WIDTH{1'b0}}};
      end
   end

   assign offset_chg = (offset != offset_q);

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      offset_d = offset_q;
      fill_d   = fill_q;
      rd_en    = 1'b0;

      if (en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end

      // A new offset invalidates the buffered history, so refill before reading.
      if (offset_chg) begin
         offset_d = offset;
         state_d  = FILL;
         fill_d   = {{A_WIDTH{1'b0}}, en};
      end else if (en) begin
         unique case (state_q)
            FILL: begin
               fill_d = fill_q + 1'b1;
               if (fill_q == dly - 1'b1) begin
                  state_d = RUN;
               end
            end
            RUN: rd_en = 1'b1;
            default: state_d = FILL;
         endcase
      end
   end

   assign ram.ram_wr_en   = rst ? 1'b0 : en;
   assign ram.ram_wr_addr = rst ? '0 : wr_ptr_q;
   assign ram.ram_din     = rst ? '0 : din;
   assign ram.ram_rd_en   = rst ? 1'b0 : rd_en;
   assign ram.ram_rd_addr = rst ? '0 : (wr_ptr_q - offset_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FILL;
         wr_ptr_q   <= '0;
         offset_q   <= '0;
         fill_q     <= '0;
         s1_valid   <= 1'b0;
         s1_zero    <= 1'b1;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         offset_q   <= offset_d;
         fill_q     <= fill_d;
         s1_valid   <= en;
         s1_zero    <= !rd_en;
         dout_valid <= s1_valid;
         // Samples without a RAM read are still in the fill window and emit zero.
         if (s1_valid) begin
            dout <= s1_zero ? '0 : ram.ram_dout;
         end
      end
   end

endmodule

// File: tb/tb_sample_delay_ctrl.sv
// Directed bench for sample_delay_ctrl with an 8-deep read-first RAM model and a
// two-deep expectation pipe matching the two-cycle output latency.
module tb_sample_delay_ctrl;

   localparam int unsigned AW = 3;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [AW-1:0] offset;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic          dout_valid;

   int total = 0;
   int bad   = 0;

   logic          p1_v = 1'b0, p2_v = 1'b0;
   logic [DW-1:0] p1_d = '0, p2_d = '0;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always #5 clk = ~clk;

   sample_delay_ctrl_if #(.A_WIDTH(AW), .D_WIDTH(DW)) ram_if ();

   sample_delay_ctrl #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .offset     (offset),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .ram        (ram_if)
   );

   // Read-first RAM: a read of the address being written returns the old contents.
   always @(posedge clk) begin
      if (ram_if.ram_rd_en) ram_if.ram_dout <= mem[ram_if.ram_rd_addr];
      if (ram_if.ram_wr_en) mem[ram_if.ram_wr_addr] <= ram_if.ram_din;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs, then check the output due from two calls earlier.
   task automatic cyc(input logic r, input logic e, input logic [AW-1:0] off,
                      input logic [DW-1:0] d, input logic [DW-1:0] ed, input logic erd);
      @(posedge clk);
      #1;
      rst = r; en = e; offset = off; din = d;
      @(negedge clk);
      if (r) p1_v = 1'b0;
      chk("dout_valid", 32'(dout_valid), 32'(p2_v));
      if (p2_v) chk("dout", 32'(dout), 32'(p2_d));
      chk("ram_wr_en", 32'(ram_if.ram_wr_en), 32'(e && !r));
      chk("ram_rd_en", 32'(ram_if.ram_rd_en), 32'(erd));
      if (e && !r) chk("ram_din", 32'(ram_if.ram_din), 32'(d));
      p2_v = p1_v; p2_d = p1_d;
      p1_v = e && !r; p1_d = ed;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; offset = '0; din = '0;

      // Reset held with en high: nothing reaches the RAM or the output.
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 3'd0, 8'd5, 8'd0, 1'b0);
         chk("rst_dout", 32'(dout), 32'd0);
      end
      cyc(1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
      chk("idle_wr_addr", 32'(ram_if.ram_wr_addr), 32'd0);
      chk("idle_rd_addr", 32'(ram_if.ram_rd_addr), 32'd0);
      chk("idle_din", 32'(ram_if.ram_din), 32'd0);

      // offset 0: full depth of 8, eight zeros then the ramp; pointer wraps 7 -> 0.
      for (int k = 0; k < 12; k++) begin
         cyc(1'b0, 1'b1, 3'd0, 8'(k + 1), (k < 8) ? 8'd0 : 8'(k - 7), k >= 8);
         if (k == 8) begin
            chk("wrap_wr_addr", 32'(ram_if.ram_wr_addr), 32'd0);
            chk("wrap_rd_addr", 32'(ram_if.ram_rd_addr), 32'd0);
         end
         if (k == 9) chk("wrap_rd_addr1", 32'(ram_if.ram_rd_addr), 32'd1);
      end
      cyc(1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
      cyc(1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);

      // offset 4, back-to-back: 0,0,0,0,1,2,3,4.
      for (int k = 0; k < 8; k++) begin
         cyc(1'b0, 1'b1, 3'd4, 8'(k + 1), (k < 4) ? 8'd0 : 8'(k - 3), k >= 4);
         if (k == 4) chk("d4_rd_addr", 32'(ram_if.ram_rd_addr), 32'd4);
      end

      // Change to offset 2 with en high: two zeros, then delay-2 data.
      cyc(1'b0, 1'b1, 3'd2, 8'd101, 8'd0,   1'b0);
      cyc(1'b0, 1'b1, 3'd2, 8'd102, 8'd0,   1'b0);
      cyc(1'b0, 1'b1, 3'd2, 8'd103, 8'd101, 1'b1);
      cyc(1'b0, 1'b1, 3'd2, 8'd104, 8'd102, 1'b1);
      cyc(1'b0, 1'b0, 3'd2, 8'd0, 8'd0, 1'b0);
      cyc(1'b0, 1'b0, 3'd2, 8'd0, 8'd0, 1'b0);

      // Restart offset 2 while idle, then sparse strobes every third cycle.
      cyc(1'b0, 1'b0, 3'd3, 8'd0, 8'd0, 1'b0);
      cyc(1'b0, 1'b0, 3'd2, 8'd0, 8'd0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, 1'b1, 3'd2, 8'(10 * (k + 1)), (k < 2) ? 8'd0 : 8'(10 * (k - 1)), k >= 2);
         if (k == 2) chk("sparse_rd_addr", 32'(ram_if.ram_rd_addr), 32'd0);
         cyc(1'b0, 1'b0, 3'd2, 8'd0, 8'd0, 1'b0);
         cyc(1'b0, 1'b0, 3'd2, 8'd0, 8'd0, 1'b0);
      end

      // Reset mid-stream: the sample still in stage 1 is dropped, then refill.
      cyc(1'b0, 1'b1, 3'd2, 8'd50, 8'd30, 1'b1);
      cyc(1'b0, 1'b1, 3'd2, 8'd51, 8'd40, 1'b1);
      cyc(1'b0, 1'b1, 3'd2, 8'd52, 8'd50, 1'b1);
      cyc(1'b1, 1'b1, 3'd2, 8'd99, 8'd0, 1'b0);
      cyc(1'b1, 1'b1, 3'd2, 8'd99, 8'd0, 1'b0);
      cyc(1'b0, 1'b1, 3'd2, 8'd60, 8'd0,  1'b0);
      cyc(1'b0, 1'b1, 3'd2, 8'd61, 8'd0,  1'b0);
      cyc(1'b0, 1'b1, 3'd2, 8'd62, 8'd60, 1'b1);
      cyc(1'b0, 1'b1, 3'd2, 8'd63, 8'd61, 1'b1);
      cyc(1'b0, 1'b0, 3'd2, 8'd0, 8'd0, 1'b0);
      cyc(1'b0, 1'b0, 3'd2, 8'd0, 8'd0, 1'b0);
      cyc(1'b0, 1'b0, 3'd2, 8'd0, 8'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
